// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S front end of the speech pipeline.
//   state_e     : controller state encoding (IDLE/WARMUP/STREAM/STOP)
//   I2S_DATA_W  : default PCM sample width
//   abs_sat()   : two's complement magnitude with saturation of the most
//                 negative code, reused by other pipeline stages
package i2s_pkg;

   localparam int I2S_DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_STREAM = 2'd2,
      ST_STOP   = 2'd3
   } state_e;

   // Magnitude of a w-bit two's complement value, sign-extended into s.
   // -2^(w-1) has no positive counterpart in w bits, so it maps to 2^(w-1)-1.
   function automatic logic [31:0] abs_sat(input logic signed [31:0] s, input int w);
      logic signed [31:0] lo;
      lo = -(32'sd1 <<< (w - 1));
      if (s == lo) return $unsigned((32'sd1 <<< (w - 1)) - 32'sd1);
      if (s < 0) return $unsigned(-s);
      return $unsigned(s);
   endfunction

endpackage

// File: rtl/i2s_stream_ctrl_if.sv
// Sample bus between the I2S receiver, the stream controller and the
// downstream framing/feature stage.
//   sample_valid/sample_data : receiver -> controller, one-cycle strobe, no back-pressure
//   out_valid/out_data/out_sof/out_eof : controller -> downstream
//   out_ready : downstream -> controller
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_data/out_sof/out_eof
// stay stable until that transfer; out_valid never depends combinationally
// on out_ready. out_sof/out_eof are meaningful only while out_valid is 1.
interface i2s_stream_ctrl_if
   import i2s_pkg::*;
#(
   parameter int DATA_W = I2S_DATA_W
) ();

   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_sof;
   logic              out_eof;
   logic              out_ready;

   // Controller side.
   modport master (
      input  sample_valid, sample_data, out_ready,
      output out_valid, out_data, out_sof, out_eof
   );

   // Receiver / downstream side.
   modport slave (
      output sample_valid, sample_data, out_ready,
      input  out_valid, out_data, out_sof, out_eof
   );

endinterface

// File: rtl/i2s_frame_energy.sv
// Per-frame energy detector: accumulates |sample| over a frame and, when the
// last sample of the frame is accepted, compares the total with thresh.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear         : drop the partial sum and force speech_valid low
//   accept        : sample is being accepted this cycle
//   last          : accepted sample is the last one of its frame
//   sample        : PCM sample (two's complement)
//   thresh        : speech threshold, only looked at on the frame-end compare
//   speech_valid  : result of the last completed frame
module i2s_frame_energy
   import i2s_pkg::*;
#(
   parameter int DATA_W = I2S_DATA_W,
   parameter int ACC_W  = 23
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              accept,
   input  logic              last,
   input  logic [DATA_W-1:0] sample,
   input  logic [ACC_W-1:0]  thresh,
   output logic              speech_valid
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] mag;
   logic [ACC_W-1:0] sum;
   logic             speech_q, speech_d;

   always_comb begin
      mag      = ACC_W'(abs_sat(32'(signed'(sample)), DATA_W));
      sum      = acc_q + mag;
      acc_d    = acc_q;
      speech_d = speech_q;
      if (clear) begin
         acc_d    = '0;
         speech_d = 1'b0;
      end else if (accept) begin
         if (last) begin
            // The frame total includes the last sample; acc restarts for the next frame.
            acc_d    = '0;
            speech_d = (sum >= thresh);
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         speech_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         speech_q <= speech_d;
      end
   end

   assign speech_valid = speech_q;

endmodule

// File: rtl/i2s_stream_ctrl.sv
// I2S front-end sequencer: powers up the receiver, discards warm-up samples,
// frames the sample stream for feature extraction and flags speech per frame.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : run request (level)
//   i2s_en         : receiver enable
//   bus            : sample input and framed output stream (master side)
//   energy_thresh  : per-frame speech threshold on sum of |sample|
//   speech_valid   : last completed frame reached the threshold
//   overrun        : sticky, a sample was dropped under back-pressure
//   clear_overrun  : clears overrun (a new drop in the same cycle wins)
//   state          : controller state (IDLE=0, WARMUP=1, STREAM=2, STOP=3)
module i2s_stream_ctrl
   import i2s_pkg::*;
#(
   parameter int WARMUP_SAMPLES = 64,
   parameter int FRAME_LEN      = 256,
   parameter int DATA_W         = I2S_DATA_W,
   parameter int ACC_W          = DATA_W - 1 + $clog2(FRAME_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   output logic              i2s_en,
   i2s_stream_ctrl_if.master bus,
   input  logic [ACC_W-1:0]  energy_thresh,
   output logic              speech_valid,
   output logic              overrun,
   input  logic              clear_overrun,
   output logic [1:0]        state
);

   localparam int IDX_W  = $clog2(FRAME_LEN);
   localparam int WARM_W = $clog2(WARMUP_SAMPLES + 1);

   state_e            state_q, state_d;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_sof_q, out_sof_d;
   logic              out_eof_q, out_eof_d;
   logic              i2s_en_q, i2s_en_d;
   logic              overrun_q, overrun_d;

   logic out_free;
   logic streaming;
   logic accept;
   logic idx_last;
   logic energy_clear;

   always_comb begin
      // Output register can take a new beat if empty or emptying this cycle.
      out_free  = !out_valid_q || bus.out_ready;
      // In STOP only the frame already begun is finished; idx 0 means it is done.
      streaming = (state_q == ST_STREAM) || ((state_q == ST_STOP) && (idx_q != '0));
      accept    = streaming && bus.sample_valid && out_free;
      idx_last  = (idx_q == IDX_W'(FRAME_LEN - 1));

      state_d     = state_q;
      warm_d      = warm_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sof_d   = out_sof_q;
      out_eof_d   = out_eof_q;
      overrun_d   = overrun_q;

      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = bus.sample_data;
         out_sof_d   = (idx_q == '0);
         out_eof_d   = idx_last;
         idx_d       = idx_q + IDX_W'(1);   // FRAME_LEN is a power of two, so this wraps
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (bus.sample_valid && out_valid_q && !bus.out_ready) begin
         overrun_d = 1'b1;
      end else if (clear_overrun) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_WARMUP;
         end
         ST_WARMUP: begin
            if (!enable) begin
               state_d = ST_IDLE;
               warm_d  = '0;
            end else if (bus.sample_valid) begin
               if (warm_q == WARM_W'(WARMUP_SAMPLES - 1)) begin
                  warm_d  = '0;
                  state_d = ST_STREAM;
               end else begin
                  warm_d = warm_q + WARM_W'(1);
               end
            end
         end
         ST_STREAM: begin
            // Nothing left of the frame (eof beat gone or never started): skip STOP.
            if (!enable) state_d = ((idx_d == '0) && !out_valid_d) ? ST_IDLE : ST_STOP;
         end
         ST_STOP: begin
            if (enable) state_d = ST_STREAM;
            else if ((idx_d == '0) && !out_valid_d) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_IDLE) idx_d = '0;
      energy_clear = (state_d == ST_IDLE);
      i2s_en_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         warm_q      <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sof_q   <= 1'b0;
         out_eof_q   <= 1'b0;
         i2s_en_q    <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         warm_q      <= warm_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sof_q   <= out_sof_d;
         out_eof_q   <= out_eof_d;
         i2s_en_q    <= i2s_en_d;
         overrun_q   <= overrun_d;
      end
   end

   i2s_frame_energy #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_energy (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (energy_clear),
      .accept       (accept),
      .last         (idx_last),
      .sample       (bus.sample_data),
      .thresh       (energy_thresh),
      .speech_valid (speech_valid)
   );

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sof   = out_sof_q;
   assign bus.out_eof   = out_eof_q;
   assign i2s_en        = i2s_en_q;
   assign overrun       = overrun_q;
   assign state         = state_q;

endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// Bench for i2s_stream_ctrl with WARMUP_SAMPLES=4, FRAME_LEN=8.
// Reference model: warm-up discard count, frame position from the count of
// accepted samples, per-frame sum of |sample| and a queue of expected beats.
module tb_i2s_stream_ctrl;

   localparam int WARMUP = 4;
   localparam int FLEN   = 8;
   localparam int DW     = 16;
   localparam int AW     = DW - 1 + $clog2(FLEN);
   localparam int W      = DW + 2;   // {sof, eof, data}

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          clear_overrun = 1'b0;
   logic [AW-1:0] energy_thresh = '0;
   logic          i2s_en;
   logic          speech_valid;
   logic          overrun;
   logic [1:0]    state;

   always #5 clk = ~clk;

   i2s_stream_ctrl_if #(.DATA_W(DW)) bus ();

   i2s_stream_ctrl #(
      .WARMUP_SAMPLES (WARMUP),
      .FRAME_LEN      (FLEN),
      .DATA_W         (DW),
      .ACC_W          (AW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .i2s_en        (i2s_en),
      .bus           (bus),
      .energy_thresh (energy_thresh),
      .speech_valid  (speech_valid),
      .overrun       (overrun),
      .clear_overrun (clear_overrun),
      .state         (state)
   );

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   int         warm_left = 0;
   int         pos = 0;
   int         frame_sum = 0;
   logic       mdl_speech = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int mag(input logic [DW-1:0] x);
      if (x == {1'b1, {(DW-1){1'b0}}}) return (1 << (DW - 1)) - 1;
      if (x[DW-1]) return (1 << DW) - int'(x);
      return int'(x);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One strobe; the model decides whether it is a warm-up discard or a framed beat.
   task automatic stream_sample(input logic [DW-1:0] x);
      bit take;
      take = (warm_left == 0);
      if (!take) begin
         warm_left--;
      end else begin
         exp_q.push_back({pos == 0, pos == FLEN - 1, x});
         frame_sum += mag(x);
         pos++;
         if (pos == FLEN) begin
            mdl_speech = (frame_sum >= int'(energy_thresh));
            pos        = 0;
            frame_sum  = 0;
         end
      end
      bus.sample_valid = 1'b1;
      bus.sample_data  = x;
      tick();
      bus.sample_valid = 1'b0;
      chk("out_valid_latency", bus.out_valid, take);
      if (take) chk("out_data_latency", bus.out_data, x);
      chk("speech_valid", speech_valid, mdl_speech);
   endtask

   task automatic const_frame(input logic [DW-1:0] x, input int thr);
      energy_thresh = AW'(thr);
      for (int i = 0; i < FLEN; i++) stream_sample(x);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_i2s_en"}, i2s_en, 0);
      chk({tag, "_state"}, state, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_data"}, bus.out_data, 0);
      chk({tag, "_out_sof"}, bus.out_sof, 0);
      chk({tag, "_out_eof"}, bus.out_eof, 0);
      chk({tag, "_speech"}, speech_valid, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL beat_unexpected observed=%0h expected=no beat",
                   {bus.out_sof, bus.out_eof, bus.out_data});
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("beat_sof_eof_data", {bus.out_sof, bus.out_eof, bus.out_data}, mon_e);
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      bus.sample_valid = 1'b0;
      bus.sample_data  = '0;
      bus.out_ready    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();
      chk("idle_after_release", state, 0);

      // Warm-up discard: 1..4 dropped, 5..12 form one frame, sum 68
      bus.out_ready = 1'b1;
      energy_thresh = AW'(68);
      warm_left     = WARMUP;
      enable        = 1'b1;
      tick();
      chk("warmup_state", state, 1);
      chk("warmup_i2s_en", i2s_en, 1);
      for (int i = 1; i <= 12; i++) begin
         stream_sample(DW'(i));
         if (i == 3) chk("still_warmup", state, 1);
         if (i == 4) chk("stream_state", state, 2);
      end
      tick();

      // Energy of constant -3 frames at threshold boundary (sum 24)
      const_frame(16'hFFFD, 25);
      const_frame(16'hFFFD, 24);
      const_frame(16'hFFFD, 25);

      // Saturating magnitude of the most negative code
      const_frame(16'h8000, 8 * 32767);
      const_frame(16'h8000, 8 * 32767 + 1);

      // Random frames with random gaps and thresholds
      for (int f = 0; f < 3; f++) begin
         energy_thresh = AW'($urandom_range(0, 8 * 32767));
         for (int i = 0; i < FLEN; i++) begin
            stream_sample(DW'($urandom));
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      tick();

      // Back-pressure: A held, B dropped, overrun set/clear behaviour
      bus.out_ready = 1'b0;
      stream_sample(16'h1234);
      bus.sample_valid = 1'b1;
      bus.sample_data  = 16'hBEEF;
      tick();
      bus.sample_valid = 1'b0;
      chk("overrun_set", overrun, 1);
      chk("held_valid", bus.out_valid, 1);
      chk("held_data", bus.out_data, 16'h1234);
      chk("held_sof", bus.out_sof, 1);
      tick();
      chk("held_data_stable", bus.out_data, 16'h1234);
      chk("overrun_sticky", overrun, 1);
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      chk("overrun_cleared", overrun, 0);
      clear_overrun    = 1'b1;
      bus.sample_valid = 1'b1;
      bus.sample_data  = 16'hDEAD;
      tick();
      clear_overrun    = 1'b0;
      bus.sample_valid = 1'b0;
      chk("overrun_set_wins", overrun, 1);
      chk("held_data_after_drop", bus.out_data, 16'h1234);
      bus.out_ready = 1'b1;
      tick();
      chk("held_beat_taken", bus.out_valid, 0);
      clear_overrun = 1'b1;
      tick();
      clear_overrun = 1'b0;
      chk("overrun_cleared_again", overrun, 0);
      energy_thresh = AW'($urandom_range(0, 8 * 32767));
      for (int i = 1; i < FLEN; i++) stream_sample(DW'($urandom));
      tick();

      // Graceful stop after the 3rd sample of a frame
      energy_thresh = AW'($urandom_range(0, 8 * 32767));
      for (int i = 0; i < 3; i++) stream_sample(DW'($urandom));
      enable = 1'b0;
      tick();
      chk("stop_state", state, 3);
      chk("stop_i2s_en", i2s_en, 1);
      for (int i = 0; i < 5; i++) stream_sample(DW'($urandom));
      chk("stop_holding_eof", state, 3);
      tick();
      mdl_speech = 1'b0;
      chk("stop_to_idle", state, 0);
      chk("idle_i2s_en", i2s_en, 0);
      chk("idle_speech_cleared", speech_valid, mdl_speech);
      chk("idle_out_valid", bus.out_valid, 0);
      warm_left = WARMUP;
      enable    = 1'b1;
      tick();
      chk("rewarm_state", state, 1);

      // Asynchronous reset mid-frame with index 5 held in the output register
      for (int i = 0; i < WARMUP + 6; i++) stream_sample(DW'($urandom));
      chk("pre_reset_valid", bus.out_valid, 1);
      #2;
      rst_n  = 1'b0;
      enable = 1'b0;
      #1;
      chk_all_zero("async_reset");
      chk("beats_out_before_reset", exp_q.size(), 1);
      exp_q.delete();
      pos        = 0;
      frame_sum  = 0;
      mdl_speech = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      warm_left     = WARMUP;
      enable        = 1'b1;
      energy_thresh = AW'($urandom_range(0, 8 * 32767));
      tick();
      chk("post_reset_warmup", state, 1);
      for (int i = 0; i < WARMUP + FLEN; i++) stream_sample(DW'($urandom));
      tick();
      tick();
      chk("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
